// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus engine: walks all 2^N_IN input vectors, captures the
// single-bit response per vector and counts mismatches against an expected table.
module truth_table_sweeper #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_y,
  input  logic [(1<<N_IN)-1:0]  i_expected,
  output logic [N_IN-1:0]       o_x,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [(1<<N_IN)-1:0]  o_table,
  output logic [N_IN:0]         o_err_count,
  output logic [N_IN-1:0]       o_first_err_idx,
  output logic                  o_pass
);

  localparam int NV = 1 << N_IN;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] IDX_LAST = N_IN'(NV - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(NV);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [N_IN-1:0]   r_idx;
  logic [CW-1:0]     r_cnt;
  logic              r_mode;
  logic [N_IN-1:0]   r_x;
  logic [NV-1:0]     r_table;
  logic [N_IN:0]     r_err_count;
  logic [N_IN-1:0]   r_first_err_idx;
  logic              r_pass;

  logic              w_sample;
  logic              w_mis;
  logic              w_last;
  logic [N_IN:0]     w_err_next;

  // Abort wins over a coincident sample event, so it masks sampling here.
  assign w_sample = (r_state == S_RUN) && !i_abort && (r_mode ? i_step : (r_cnt == CNT_LAST));
  assign w_mis    = (i_y != i_expected[r_idx]);
  assign w_last   = (r_idx == IDX_LAST);
  assign w_err_next = (w_sample && w_mis && (r_err_count != ERR_MAX))
                    ? r_err_count + 1'b1 : r_err_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN: begin
        if (i_abort)                 w_next = S_IDLE;
        else if (w_sample && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == S_RUN);
    o_done = (r_state == S_DONE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx           <= '0;
      r_cnt           <= '0;
      r_mode          <= 1'b0;
      r_x             <= '0;
      r_table         <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_idx           <= '0;
            r_cnt           <= '0;
            r_mode          <= i_step_mode;
            r_x             <= '0;
            r_table         <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_pass          <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_x <= '0;
          end else if (w_sample) begin
            r_table[r_idx] <= i_y;
            r_err_count    <= w_err_next;
            if (w_mis && (r_err_count == '0)) r_first_err_idx <= r_idx;
            // Pass is registered on entry to DONE so it is valid alongside o_done.
            if (w_last) begin
              r_pass <= (w_err_next == '0);
            end else begin
              r_idx <= r_idx + 1'b1;
              r_x   <= r_idx + 1'b1;
              r_cnt <= '0;
            end
          end else if (!r_mode) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_x <= '0;
        default: r_x <= '0;
      endcase
    end
  end

  assign o_x             = r_x;
  assign o_table         = r_table;
  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;
  assign o_pass          = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: random response functions and expected tables
// checked against a vector-level model; second instance covers HOLD_CYCLES=1.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, abort_s = 1'b0, step_mode = 1'b0, step = 1'b0;
  logic [15:0] expected = '0;
  logic [15:0] yf = '0;
  logic        y;
  logic [3:0]  x;
  logic        busy, done, pass;
  logic [15:0] tbl;
  logic [4:0]  errc;
  logic [3:0]  first;

  logic        start1 = 1'b0;
  logic [15:0] yf1 = '0;
  logic        y1;
  logic [3:0]  x1;
  logic        busy1, done1, pass1;
  logic [15:0] tbl1;
  logic [4:0]  errc1;
  logic [3:0]  first1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign y  = yf[x];
  assign y1 = yf1[x1];

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort_s),
    .i_step_mode(step_mode), .i_step(step), .i_y(y), .i_expected(expected),
    .o_x(x), .o_busy(busy), .o_done(done), .o_table(tbl),
    .o_err_count(errc), .o_first_err_idx(first), .o_pass(pass));

  truth_table_sweeper #(.N_IN(4), .HOLD_CYCLES(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_abort(1'b0),
    .i_step_mode(1'b0), .i_step(1'b0), .i_y(y1), .i_expected(expected),
    .o_x(x1), .o_busy(busy1), .o_done(done1), .o_table(tbl1),
    .o_err_count(errc1), .o_first_err_idx(first1), .o_pass(pass1));

  // Model: over the first nvec vectors, captured bit k is f(k); errors are the
  // differing bits of f and the expected table.
  function automatic void model(input logic [15:0] f, input logic [15:0] e, input int nvec,
                                output logic [15:0] t, output int err, output int fst);
    t = '0; err = 0; fst = 0;
    for (int k = 0; k < nvec; k++) begin
      t[k] = f[k];
      if (f[k] != e[k]) begin
        if (err == 0) fst = k;
        err++;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({x, busy, done, tbl, errc, first, pass} !== '0) begin
      miscompares++; $display("FAIL reset_outputs got x=%0d busy=%0b done=%0b tbl=%h err=%0d first=%0d pass=%0b want all 0",
                              x, busy, done, tbl, errc, first, pass);
    end
    vectors++;
    if ({x1, busy1, done1, tbl1, errc1, first1, pass1} !== '0) begin
      miscompares++; $display("FAIL reset_outputs_h1 got nonzero outputs want all 0");
    end
  endtask

  task automatic test_timed(input string name, input logic [15:0] f, input logic [15:0] e);
    logic [15:0] t; int err, fst; int n;
    yf = f; expected = e; step_mode = 1'b0;
    model(f, e, 16, t, err, fst);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (busy && n < 2000) begin
      vectors++;
      if (x !== 4'(n / 10)) begin
        miscompares++; $display("FAIL %s x_hold cycle %0d got %0d want %0d", name, n, x, n / 10);
      end
      tick(); n++;
    end
    vectors++;
    if (n != 160) begin miscompares++; $display("FAIL %s busy_cycles got %0d want 160", name, n); end
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL %s done_pulse got %0b want 1", name, done); end
    vectors++;
    if (tbl !== t) begin miscompares++; $display("FAIL %s table got %h want %h", name, tbl, t); end
    vectors++;
    if (errc !== 5'(err)) begin miscompares++; $display("FAIL %s err_count got %0d want %0d", name, errc, err); end
    vectors++;
    if (first !== 4'(fst)) begin miscompares++; $display("FAIL %s first_err got %0d want %0d", name, first, fst); end
    vectors++;
    if (pass !== (err == 0)) begin miscompares++; $display("FAIL %s pass got %0b want %0b", name, pass, err == 0); end
    tick();
    vectors++;
    if ({done, busy, x} !== '0) begin
      miscompares++; $display("FAIL %s after_done got done=%0b busy=%0b x=%0d want 0", name, done, busy, x);
    end
    vectors++;
    if (tbl !== t || pass !== (err == 0)) begin
      miscompares++; $display("FAIL %s results_hold got tbl=%h pass=%0b want tbl=%h pass=%0b", name, tbl, pass, t, err == 0);
    end
  endtask

  task automatic test_step_mode();
    logic [15:0] t; int err, fst;
    yf = 16'h6996; expected = 16'h6996;
    model(yf, expected, 16, t, err, fst);
    step_mode = 1'b1; start = 1'b1; tick(); start = 1'b0; step_mode = 1'b0;
    for (int v = 0; v < 16; v++) begin
      tick(); tick();
      vectors++;
      if (x !== 4'(v) || busy !== 1'b1) begin
        miscompares++; $display("FAIL step_hold got x=%0d busy=%0b want x=%0d busy=1", x, busy, v);
      end
      step = 1'b1; tick(); step = 1'b0;
    end
    vectors++;
    if (done !== 1'b1) begin miscompares++; $display("FAIL step_done got %0b want 1", done); end
    vectors++;
    if (tbl !== t || errc !== 5'(err) || pass !== 1'b1) begin
      miscompares++; $display("FAIL step_results got tbl=%h err=%0d pass=%0b want tbl=%h err=%0d pass=1", tbl, errc, pass, t, err);
    end
  endtask

  task automatic test_abort();
    logic [15:0] f, e, t; int err, fst; int n;
    f = 16'($urandom); e = 16'($urandom);
    yf = f; expected = e; step_mode = 1'b0;
    model(f, e, 7, t, err, fst);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (x != 4'd5 && n < 200) begin tick(); n++; end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || x !== 4'd5) begin
      miscompares++; $display("FAIL start_while_busy got busy=%0b x=%0d want busy=1 x=5", busy, x);
    end
    n = 0;
    while (x != 4'd7 && n < 200) begin tick(); n++; end
    vectors++;
    if (x !== 4'd7) begin miscompares++; $display("FAIL abort_reach_idx7 got x=%0d want 7", x); end
    tick();
    abort_s = 1'b1; tick(); abort_s = 1'b0;
    vectors++;
    if (busy !== 1'b0 || x !== 4'd0 || done !== 1'b0 || pass !== 1'b0) begin
      miscompares++; $display("FAIL abort_state got busy=%0b x=%0d done=%0b pass=%0b want 0 0 0 0", busy, x, done, pass);
    end
    vectors++;
    if (tbl !== t || errc !== 5'(err) || first !== 4'(fst)) begin
      miscompares++; $display("FAIL abort_partial got tbl=%h err=%0d first=%0d want tbl=%h err=%0d first=%0d",
                              tbl, errc, first, t, err, fst);
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        miscompares++; $display("FAIL abort_no_done got done=%0b busy=%0b want 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    yf = 16'h6996; expected = 16'h6996;
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (x != 4'd9 && n < 300) begin tick(); n++; end
    #2 rst_n = 1'b0; #1;
    vectors++;
    if ({x, busy, done, tbl, errc, first, pass} !== '0) begin
      miscompares++; $display("FAIL reset_mid got x=%0d busy=%0b tbl=%h err=%0d want all 0", x, busy, tbl, errc);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL reset_mid_idle got busy=%0b done=%0b want 0 0", busy, done);
      end
    end
  endtask

  task automatic test_hold1();
    logic [15:0] t; int err, fst; int n;
    yf1 = 16'($urandom); expected = 16'($urandom);
    model(yf1, expected, 16, t, err, fst);
    start1 = 1'b1; tick(); start1 = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      vectors++;
      if (x1 !== 4'(n)) begin miscompares++; $display("FAIL hold1_x cycle %0d got %0d want %0d", n, x1, n); end
      tick(); n++;
    end
    vectors++;
    if (n != 16) begin miscompares++; $display("FAIL hold1_busy_cycles got %0d want 16", n); end
    vectors++;
    if (done1 !== 1'b1 || tbl1 !== t || errc1 !== 5'(err) || first1 !== 4'(fst) || pass1 !== (err == 0)) begin
      miscompares++; $display("FAIL hold1_results got done=%0b tbl=%h err=%0d first=%0d pass=%0b want 1 %h %0d %0d %0b",
                              done1, tbl1, errc1, first1, pass1, t, err, fst, err == 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 rst_n = 1'b1;
    tick();
    test_reset();
    test_timed("parity_pass", 16'h6996, 16'h6996);
    test_timed("single_mismatch", 16'h6996, 16'h6997);
    test_timed("multi_mismatch", 16'h0000, 16'hFFFF);
    for (int i = 0; i < 3; i++) test_timed("random", 16'($urandom), 16'($urandom));
    test_step_mode();
    tick();
    test_abort();
    test_timed("after_abort", 16'h6996, 16'h6996);
    test_reset_mid_sweep();
    test_hold1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential exhaustive-stimulus engine for combinational blocks with N_IN inputs.
- Drives all 2^N_IN input combinations in ascending binary order, holding each vector for HOLD_CYCLES clocks.
- Samples the single-bit DUT response into a captured truth table and compares it bit-for-bit against an expected table.
- Sits between a combinational UUT and a status/readout path; replaces hand-written per-vector stimulus.

Parameters:
- N_IN, 4, number of DUT inputs; legal 1..8.
- HOLD_CYCLES, 10, clocks each vector is held in timed mode; legal >=1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_start  in  1  begin sweep; honoured only in IDLE.
- i_abort  in  1  cancel the sweep; honoured only in RUN.
- i_step_mode  in  1  0 = timed advance, 1 = advance on i_step; sampled at start.
- i_step  in  1  single-step strobe; used only in step mode.
- i_y  in  1  DUT response.
- i_expected  in  2^N_IN  expected table; bit k is the expected y for input vector k.
- o_x  out  N_IN  stimulus to DUT; MSB = first input (a).
- o_busy  out  1  high in RUN.
- o_done  out  1  one-cycle pulse at sweep completion.
- o_table  out  2^N_IN  captured responses; bit k = y for vector k.
- o_err_count  out  N_IN+1  number of mismatches.
- o_first_err_idx  out  N_IN  index of the first mismatch.
- o_pass  out  1  high when the last completed sweep had 0 errors.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all outputs 0; internal idx=0, cnt=0, mode=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start=1 at an edge causes the following on that edge: go to RUN; o_x=0, idx=0, cnt=0; o_table, o_err_count, o_first_err_idx and o_pass cleared; latch i_step_mode; o_busy=1.
- RUN, sample event:
  - Timed mode: sample event when cnt==HOLD_CYCLES-1, otherwise cnt++.
  - Step mode: sample event on any edge with i_step=1; cnt is unused.
  - On a sample event: o_table[idx] <= i_y.
  - If i_y != i_expected[idx]: o_err_count++ (saturates at 2^N_IN), and o_first_err_idx <= idx if o_err_count was 0.
- RUN, advance:
  - If idx == 2^N_IN-1: go to DONE.
  - Else: idx++, o_x <= idx+1, cnt <= 0.
- Timing:
  - Each vector is stable for exactly HOLD_CYCLES clocks in timed mode.
  - i_y is sampled in the last cycle of the hold.
  - Full timed sweep: o_busy high for 2^N_IN*HOLD_CYCLES cycles.
- DONE (one cycle): o_done=1, o_busy=0, o_pass <= (final o_err_count==0), then go to IDLE. o_x returns to 0 on exit.
- Results (o_table, counts, o_pass) hold until the next accepted i_start or reset.
- Abort: i_abort=1 in RUN takes precedence over a sample event on the same edge.
  - Go to IDLE, o_x=0, o_busy=0.
  - No o_done pulse; o_pass stays 0.
  - Partial o_table and counts are retained.
- Ignored inputs:
  - i_start in RUN or DONE.
  - i_abort in IDLE or DONE.
  - i_step in timed mode or when not in RUN.
  - Changes to i_step_mode mid-sweep.
- i_expected is sampled live at each sample event and must be held stable by the user during the sweep.
- Reset mid-sweep: immediate return to the reset state; no done pulse.
- Width rules:
  - idx has N_IN bits and never wraps within a sweep.
  - cnt has clog2(HOLD_CYCLES+1) bits.
  - o_err_count has N_IN+1 bits, so 2^N_IN errors are representable without overflow.

Test Plan:
- Parity pass: defaults, i_y = XOR of o_x bits, i_expected=16'h6996, timed mode, start at edge 0 -> o_x steps 0..15 every 10 clocks; o_done pulses in cycle 161; o_table=16'h6996; o_err_count=0; o_pass=1.
- Single mismatch: same DUT, i_expected=16'h6997 -> o_err_count=1, o_first_err_idx=0, o_pass=0, o_table=16'h6996.
- Multiple mismatches: i_y tied to 0, i_expected=16'hFFFF -> o_err_count=16 (no overflow), o_first_err_idx=0, o_table=16'h0000.
- Step mode: i_step_mode=1, i_step pulsed every 3rd clock -> o_x advances only on i_step; o_done one cycle after the 16th i_step; results identical to the parity-pass case.
- Abort and start-while-busy:
  - i_start pulsed again at idx=5 -> no effect.
  - i_abort at idx=7 -> IDLE next edge, o_x=0, no o_done, o_table[6:0] valid, o_pass=0.
  - A new i_start then runs a full sweep.
- Reset mid-sweep and HOLD_CYCLES=1:
  - i_rst_n low at idx=9 -> all outputs 0 asynchronously.
  - With HOLD_CYCLES=1, a full sweep completes with o_busy high for exactly 16 cycles.
